// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the Conv column sequencer.
package conv_pkg;

  localparam int BIT_LEN    = 8;
  localparam int NB_ADDRESS = 10;
  localparam int BRAM_LAT   = 1;
  localparam int CONV_LAT   = 2;

  localparam int KER_COLS = 3;
  localparam int WIN_COLS = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KER   = 2'd1,
    S_IMG   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register carrying a {valid, tag} pair per stage; the tag is
// only kept alongside a valid bit so a stray tag can never fire on its own.
module tag_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_valid,
  input  logic i_tag,
  output logic o_valid,
  output logic o_tag,
  output logic o_any_head
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_tag;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_valid <= '0;
      r_tag   <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_tag[0]   <= i_valid & i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  assign o_valid    = r_valid[DEPTH-1];
  assign o_tag      = r_tag[DEPTH-1];
  // Occupancy of every stage except the output one.
  assign o_any_head = |(r_valid & ~(DEPTH'(1) << (DEPTH - 1)));

endmodule

// File: rtl/conv_seq_ctrl.sv
// Conv sequencer: loads a 3-column kernel, then streams BRAM image columns and
// writes Conv results back to bank 0. Optional stall input under CONV_SEQ_PAUSE_EN.
module conv_seq_ctrl #(
  parameter int NB_ADDRESS = 10,
  parameter int BRAM_LAT   = 1,
  parameter int CONV_LAT   = 2
) (
  input  logic                  CLK100MHZ,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [NB_ADDRESS:0]   i_ncols,
  input  logic                  i_ker_valid,
`ifdef CONV_SEQ_PAUSE_EN
  input  logic                  i_pause,
`endif
  output logic                  o_ker_ready,
  output logic                  o_sel_ki,
  output logic                  o_valid,
  output logic [NB_ADDRESS-1:0] o_read_addr,
  output logic [NB_ADDRESS-1:0] o_write_addr,
  output logic                  o_wr_enable,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  import conv_pkg::*;

  localparam int NCW = NB_ADDRESS + 1;
  localparam logic [NCW-1:0] NCOLS_MAX = NCW'(1) << NB_ADDRESS;

  state_t                r_state;
  logic [NCW-1:0]        r_ncols;
  logic [1:0]            r_ker_cnt;
  logic [NB_ADDRESS-1:0] r_read_addr;
  logic [NB_ADDRESS-1:0] r_write_addr;
  logic                  r_sel_ki;
  logic                  r_done;
  logic                  r_err;

  logic                  w_pause;
  logic                  w_ker_ready;
  logic                  w_ker_beat;
  logic                  w_issue;
  logic                  w_issue_tag;
  logic                  w_last;
  logic [NB_ADDRESS-1:0] w_last_addr;
  logic [NCW-1:0]        w_ncols_clamped;
  logic                  w_img_valid;
  logic                  w_img_tag;
  logic                  w_rd_head;
  logic                  w_conv_valid;
  logic                  w_conv_tag;
  logic                  w_wr_head;
  logic                  w_drain_done;

`ifdef CONV_SEQ_PAUSE_EN
  assign w_pause = i_pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_ncols_clamped = (i_ncols > NCOLS_MAX) ? NCOLS_MAX : i_ncols;
  assign w_last_addr     = NB_ADDRESS'(r_ncols - NCW'(1));

  // Handshake: a kernel column transfers on any cycle with i_ker_valid and o_ker_ready both high.
  assign w_ker_ready = (r_state == S_KER) & ~w_pause;
  assign w_ker_beat  = w_ker_ready & i_ker_valid;

  assign w_issue     = (r_state == S_IMG) & ~w_pause;
  assign w_issue_tag = (r_read_addr >= NB_ADDRESS'(WIN_COLS - 1));
  assign w_last      = (r_read_addr == w_last_addr);

  // Read-issue flag aligned to BRAM data, then window tag aligned to Conv output.
  tag_delay_line #(.DEPTH(BRAM_LAT)) u_rd_dly (
    .i_clk      (CLK100MHZ),
    .i_reset    (i_reset),
    .i_valid    (w_issue),
    .i_tag      (w_issue_tag),
    .o_valid    (w_img_valid),
    .o_tag      (w_img_tag),
    .o_any_head (w_rd_head)
  );

  tag_delay_line #(.DEPTH(CONV_LAT)) u_wr_dly (
    .i_clk      (CLK100MHZ),
    .i_reset    (i_reset),
    .i_valid    (w_img_valid),
    .i_tag      (w_img_tag),
    .o_valid    (w_conv_valid),
    .o_tag      (w_conv_tag),
    .o_any_head (w_wr_head)
  );

  // Done may fire while the final write is on the output stage, so o_done
  // lands the cycle right after the last o_wr_enable.
  assign w_drain_done = ~w_rd_head & ~w_img_valid & ~w_wr_head;

  always_ff @(posedge CLK100MHZ) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_ncols      <= '0;
      r_ker_cnt    <= '0;
      r_read_addr  <= '0;
      r_write_addr <= '0;
      r_sel_ki     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (o_wr_enable) r_write_addr <= r_write_addr + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_ncols      <= w_ncols_clamped;
            r_err        <= 1'b0;
            r_ker_cnt    <= '0;
            r_read_addr  <= '0;
            r_write_addr <= '0;
            if (i_ncols < NCW'(WIN_COLS)) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_state <= S_KER;
            end
          end
        end
        S_KER: begin
          if (w_ker_beat) begin
            if (r_ker_cnt == 2'(KER_COLS - 1)) begin
              r_ker_cnt <= '0;
              r_sel_ki  <= 1'b1;
              r_state   <= S_IMG;
            end else begin
              r_ker_cnt <= r_ker_cnt + 1'b1;
            end
          end
        end
        S_IMG: begin
          if (w_issue) begin
            if (w_last) r_state <= S_DRAIN;
            else        r_read_addr <= r_read_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            r_state  <= S_IDLE;
            r_sel_ki <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ker_ready  = w_ker_ready;
  assign o_sel_ki     = r_sel_ki;
  assign o_valid      = w_ker_beat | w_img_valid;
  assign o_read_addr  = r_read_addr;
  assign o_write_addr = r_write_addr;
  assign o_wr_enable  = w_conv_valid & w_conv_tag;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: frame vector table, scoreboard of
// expected write addresses, plus reset-mid-frame and pause sequences.
module tb_conv_seq_ctrl;
  import conv_pkg::*;

  localparam int NB  = NB_ADDRESS;
  localparam int NCW = NB + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           i_reset;
  logic           i_start;
  logic [NCW-1:0] i_ncols;
  logic           i_ker_valid;
`ifdef CONV_SEQ_PAUSE_EN
  logic           i_pause;
`endif
  logic           o_ker_ready, o_sel_ki, o_valid, o_wr_enable, o_busy, o_done, o_err;
  logic [NB-1:0]  o_read_addr, o_write_addr;

  conv_seq_ctrl #(.NB_ADDRESS(NB), .BRAM_LAT(BRAM_LAT), .CONV_LAT(CONV_LAT)) dut (
    .CLK100MHZ    (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_ncols      (i_ncols),
    .i_ker_valid  (i_ker_valid),
`ifdef CONV_SEQ_PAUSE_EN
    .i_pause      (i_pause),
`endif
    .o_ker_ready  (o_ker_ready),
    .o_sel_ki     (o_sel_ki),
    .o_valid      (o_valid),
    .o_read_addr  (o_read_addr),
    .o_write_addr (o_write_addr),
    .o_wr_enable  (o_wr_enable),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  // ---------------- scoreboard ----------------
  logic [NB-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver / monitor ----------------
  // ker_mode: 0 = valid held, 1 = toggling 1,0,1,0,1, 2 = random.
  task automatic run_frame(input int ncols, input int ker_mode, input int pause_at,
                           input bit poke, output int frame_len);
    int eff, nwr, cyc, kidx, ready_cnt, kbeats, ibeats, max_rd;
    int done_cnt, done_cyc, last_wr, pause_left, pause_bad, tail;
    bit exp_err, done_seen, paused_once, poked, pause_now, kv;
    logic [NB-1:0] exp_addr;
    eff     = (ncols > (1 << NB)) ? (1 << NB) : ncols;
    exp_err = (ncols < WIN_COLS);
    nwr     = exp_err ? 0 : eff - 2;
    for (int i = 0; i < nwr; i++) exp_q.push_back(NB'(i));
    cyc = 0; kidx = 0; ready_cnt = 0; kbeats = 0; ibeats = 0; max_rd = -1;
    done_cnt = 0; done_cyc = -1; last_wr = -1; pause_left = 0; pause_bad = 0; tail = 0;
    done_seen = 0; paused_once = 0; poked = 0;
    while (tail < 4 && cyc < eff + 200) begin
      @(negedge clk);
      i_start = (cyc == 0);
      if (cyc == 0) i_ncols = NCW'(ncols);
      if (poke && !poked && o_sel_ki && o_read_addr == NB'(2)) begin
        i_start = 1'b1;
        i_ncols = NCW'(3);
        poked   = 1'b1;
      end
      kv = 1'b0;
      if (o_ker_ready) begin
        case (ker_mode)
          0:       kv = 1'b1;
          1:       kv = (kidx % 2 == 0);
          default: kv = 1'($urandom_range(0, 1));
        endcase
        kidx++;
      end
      i_ker_valid = kv;
      if (pause_at >= 0 && !paused_once && o_sel_ki && o_read_addr == NB'(pause_at)) begin
        pause_left  = 4;
        paused_once = 1'b1;
      end
      pause_now = (pause_left > 0);
      if (pause_left > 0) pause_left--;
`ifdef CONV_SEQ_PAUSE_EN
      i_pause = pause_now;
`endif
      #1;
      if (pause_now && o_read_addr != NB'(pause_at)) pause_bad++;
      if (o_ker_ready) ready_cnt++;
      if (o_valid && !o_sel_ki) kbeats++;
      if (o_valid && o_sel_ki) ibeats++;
      if (o_sel_ki && int'(o_read_addr) > max_rd) max_rd = int'(o_read_addr);
      if (o_wr_enable) begin
        last_wr = cyc;
        if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          exp_addr = exp_q.pop_front();
          check("wr_addr", o_write_addr, exp_addr);
        end
      end
      if (o_done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_seen = 1'b1;
      end
      if (done_seen) tail++;
      cyc++;
    end
    i_start = 1'b0;
    i_ker_valid = 1'b0;
`ifdef CONV_SEQ_PAUSE_EN
    i_pause = 1'b0;
`endif
    check("done_count", done_cnt, 1);
    check("writes_left", exp_q.size(), 0);
    exp_q.delete();
    check("img_beats", ibeats, exp_err ? 0 : eff);
    check("ker_beats", kbeats, exp_err ? 0 : KER_COLS);
    check("max_read_addr", max_rd, exp_err ? -1 : eff - 1);
    check("err", o_err, exp_err);
    check("busy_end", o_busy, 0);
    if (ker_mode == 0) check("ker_ready_cycles", ready_cnt, exp_err ? 0 : KER_COLS);
    if (nwr > 0) check("done_after_last_wr", done_cyc, last_wr + 1);
    if (pause_at >= 0) check("pause_hold", pause_bad, 0);
    frame_len = done_cyc;
  endtask

  typedef struct {
    int ncols;
    int ker_mode;
    bit poke;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int len0, len1;
    bit reached;
    int wr_after, busy_after;
    vecs[0] = '{ncols: 8,    ker_mode: 0, poke: 1'b0};
    vecs[1] = '{ncols: 3,    ker_mode: 0, poke: 1'b0};
    vecs[2] = '{ncols: 2,    ker_mode: 0, poke: 1'b0};
    vecs[3] = '{ncols: 4,    ker_mode: 1, poke: 1'b0};
    vecs[4] = '{ncols: 0,    ker_mode: 0, poke: 1'b0};
    vecs[5] = '{ncols: 5,    ker_mode: 2, poke: 1'b0};
    vecs[6] = '{ncols: 6,    ker_mode: 0, poke: 1'b1};
    vecs[7] = '{ncols: 1030, ker_mode: 0, poke: 1'b0};

    i_reset = 1'b0; i_start = 1'b0; i_ncols = '0; i_ker_valid = 1'b0;
`ifdef CONV_SEQ_PAUSE_EN
    i_pause = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          {o_ker_ready, o_sel_ki, o_valid, o_wr_enable, o_busy, o_done, o_err, o_read_addr, o_write_addr}, 0);
    i_reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) run_frame(vecs[v].ncols, vecs[v].ker_mode, -1, vecs[v].poke, len0);

    // Reset while streaming column 5 of 10.
    @(negedge clk);
    i_start = 1'b1; i_ncols = NCW'(10); i_ker_valid = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 60 && !reached; k++) begin
      @(negedge clk);
      #1;
      reached = o_sel_ki && o_read_addr == NB'(5);
    end
    check("rst_reached_col5", reached, 1);
    i_reset = 1'b0; i_ker_valid = 1'b0;
    @(negedge clk);
    #1;
    check("midframe_reset_outputs",
          {o_ker_ready, o_sel_ki, o_valid, o_wr_enable, o_busy, o_done, o_err, o_read_addr, o_write_addr}, 0);
    i_reset = 1'b1;
    wr_after = 0; busy_after = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (o_wr_enable) wr_after++;
      if (o_busy) busy_after++;
    end
    check("wr_after_reset", wr_after, 0);
    check("busy_after_reset", busy_after, 0);

`ifdef CONV_SEQ_PAUSE_EN
    run_frame(10, 0, -1, 1'b0, len0);
    run_frame(10, 0, 4, 1'b0, len1);
    check("pause_done_delay", len1, len0 + 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
